// File: rtl/rv32i_types.sv
// Shared types for the decode/writeback register file and its busy-bit scoreboard.
// Ports: none (package). Provides register-index and tag types plus a popcount helper.
// Consumers: sb_table, regfile_scoreboard.
package rv32i_types;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;
  localparam int SB_TAG_W  = 3;

  typedef logic [31:0]          rv32i_word;
  typedef logic [REG_AW-1:0]    rv32i_reg;
  typedef logic [SB_TAG_W-1:0]  sb_tag_t;

  // Number of set bits in a 32-entry busy vector (0..32 fits in 6 bits).
  function automatic logic [5:0] popcount32(input logic [REG_COUNT-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_table.sv
// Busy-bit / producer-tag scoreboard for the 32 architectural registers.
// Ports: issue_* allocates a destination, wb_* presents a writeback to be judged,
//        flush_i clears all busy bits; outputs are the busy vector, accept/release
//        decisions for the current writeback, and a registered busy count.
module sb_table
  import rv32i_types::*;
#(
  parameter int TAG_W = SB_TAG_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  input  rv32i_reg             issue_rd_i,
  input  logic [TAG_W-1:0]     issue_tag_i,
  input  logic                 wb_valid_i,
  input  rv32i_reg             wb_rd_i,
  input  logic [TAG_W-1:0]     wb_tag_i,
  input  logic                 flush_i,
  output logic [REG_COUNT-1:0] busy_o,
  output logic                 wb_accept_o,
  output logic                 wb_release_o,
  output logic [5:0]           busy_cnt_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]     tag_q [REG_COUNT];
  logic [TAG_W-1:0]     tag_d [REG_COUNT];
  logic [5:0]           cnt_q;
  logic                 tag_match;

  assign tag_match = (tag_q[wb_rd_i] == wb_tag_i);

  // A writeback is superseded only when its register is busy under a different tag.
  // Writes to x0 are "accepted" so the producer retires, but never change state.
  assign wb_accept_o  = wb_valid_i &&
                        ((wb_rd_i == '0) || !busy_q[wb_rd_i] || tag_match);
  assign wb_release_o = wb_valid_i && (wb_rd_i != '0) && busy_q[wb_rd_i] && tag_match;

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush_i) begin
      // Squash: every pending producer is forgotten, same-cycle issue included.
      busy_d = '0;
    end else begin
      if (wb_release_o) begin
        busy_d[wb_rd_i] = 1'b0;
      end
      // Issue is applied after release so a same-register issue keeps the bit set.
      if (issue_valid_i && (issue_rd_i != '0)) begin
        busy_d[issue_rd_i] = 1'b1;
        tag_d[issue_rd_i]  = issue_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= popcount32(busy_d);
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-to-read bypass and a tagged busy scoreboard.
// Ports: rd_addr/rd_en in, rd_data/rd_busy/stall out (combinational, bypassed);
//        issue_*, wb_*, commit_valid, flush in; wb_accept, instret, busy_cnt out.
module regfile_scoreboard
  import rv32i_types::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,   // 1..4
  parameter int TAG_W  = SB_TAG_W,
  parameter int CNT_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*5-1:0]      rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [TAG_W-1:0]         wb_tag,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     wb_accept,
  input  logic                     commit_valid,
  input  logic                     flush,
  output logic [CNT_W-1:0]         instret,
  output logic [5:0]               busy_cnt
);

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [CNT_W-1:0]     instret_q, instret_d;
  logic [REG_COUNT-1:0] busy;
  logic                 wb_release;
  logic                 wb_write;

  sb_table #(
    .TAG_W (TAG_W)
  ) u_sb_table (
    .clk_i         (clk),
    .rst_ni        (rst),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_tag_i   (issue_tag),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .wb_tag_i      (wb_tag),
    .flush_i       (flush),
    .busy_o        (busy),
    .wb_accept_o   (wb_accept),
    .wb_release_o  (wb_release),
    .busy_cnt_o    (busy_cnt)
  );

  assign wb_write  = wb_accept && (wb_rd != '0);
  assign instret_d = commit_valid ? (instret_q + CNT_W'(1)) : instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      instret_q <= instret_d;
      if (wb_write) begin
        regs_q[wb_rd] <= wb_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rv32i_reg addr;
    logic     bypass;

    assign addr   = rd_addr[5*g +: 5];
    assign bypass = wb_write && (wb_rd == addr);

    assign rd_data[XLEN*g +: XLEN] = (addr == '0) ? '0 :
                                     bypass       ? wb_data :
                                                    regs_q[addr];

    // The producer completing this cycle no longer blocks its consumer.
    assign rd_busy[g] = busy[addr] && !(wb_release && (wb_rd == addr));
  end

  assign stall   = |(rd_busy & rd_en);
  assign instret = instret_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 32, NUM_RD = 2, TAG_W = 3, CNT_W = 64;

  localparam int S_D0 = 0, S_D1 = 1, S_BUSY = 2, S_STALL = 3,
                 S_BCNT = 4, S_INST = 5, S_ACC = 6, S_WINST = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NUM_RD*5-1:0]    rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   stall;
  logic [NUM_RD-1:0]      rd_en;
  logic                   issue_valid;
  logic [4:0]             issue_rd;
  logic [TAG_W-1:0]       issue_tag;
  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic [TAG_W-1:0]       wb_tag;
  logic [XLEN-1:0]        wb_data;
  logic                   wb_accept;
  logic                   commit_valid;
  logic                   flush;
  logic [CNT_W-1:0]       instret;
  logic [5:0]             busy_cnt;

  // Narrow-counter instance used only to observe counter wrap-around.
  logic [NUM_RD*XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]      w_rd_busy;
  logic                   w_stall;
  logic                   w_wb_accept;
  logic [3:0]             w_instret;
  logic [5:0]             w_busy_cnt;

  regfile_scoreboard #(.XLEN(XLEN), .NUM_RD(NUM_RD), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .stall(stall), .rd_en(rd_en), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tag(issue_tag), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_accept(wb_accept), .commit_valid(commit_valid),
    .flush(flush), .instret(instret), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NUM_RD(NUM_RD), .TAG_W(TAG_W), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .stall(w_stall), .rd_en(rd_en), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tag(issue_tag), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_accept(w_wb_accept), .commit_valid(commit_valid),
    .flush(flush), .instret(w_instret), .busy_cnt(w_busy_cnt)
  );

  typedef struct {
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t        mon_e;
  logic [63:0] mon_act;

  // Monitor: every expectation queued for the current cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        S_D0:    mon_act = {32'd0, rd_data[31:0]};
        S_D1:    mon_act = {32'd0, rd_data[63:32]};
        S_BUSY:  mon_act = {62'd0, rd_busy};
        S_STALL: mon_act = {63'd0, stall};
        S_BCNT:  mon_act = {58'd0, busy_cnt};
        S_INST:  mon_act = instret;
        S_ACC:   mon_act = {63'd0, wb_accept};
        S_WINST: mon_act = {60'd0, w_instret};
        default: mon_act = 'x;
      endcase
      n_checks++;
      if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", mon_e.name, mon_act, mon_e.val);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [63:0] v, input string nm);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    wb_valid     = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
    rd_addr = {a1, a0};
    rd_en   = en;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [2:0] t);
    issue_valid = 1'b1;
    issue_rd    = r;
    issue_tag   = t;
  endtask

  task automatic do_wb(input logic [4:0] r, input logic [2:0] t, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_tag   = t;
    wb_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    issue_rd = '0; issue_tag = '0; wb_rd = '0; wb_tag = '0; wb_data = '0;
    set_rd(5'd0, 5'd0, 2'b00);
    repeat (3) next_cycle();
    rst = 1'b1;

    // Reset state on all ports
    set_rd(5'd0, 5'd5, 2'b11);
    expect_val(S_D0, 0, "reset_rd0");
    expect_val(S_D1, 0, "reset_rd1");
    expect_val(S_BUSY, 0, "reset_busy");
    expect_val(S_STALL, 0, "reset_stall");
    expect_val(S_BCNT, 0, "reset_busy_cnt");
    expect_val(S_INST, 0, "reset_instret");
    next_cycle();

    // Bypass on a non-busy register
    set_rd(5'd5, 5'd0, 2'b11);
    do_wb(5'd5, 3'd0, 32'hDEAD_BEEF);
    expect_val(S_ACC, 1, "bypass_accept");
    expect_val(S_D0, 64'hDEAD_BEEF, "bypass_same_cycle");
    next_cycle();
    idle();
    expect_val(S_D0, 64'hDEAD_BEEF, "bypass_next_cycle");
    next_cycle();

    // Busy / stall, rd_en masking, release with bypass
    do_issue(5'd7, 3'd3);
    set_rd(5'd7, 5'd0, 2'b01);
    expect_val(S_BUSY, 0, "issue_not_yet_busy");
    next_cycle();
    idle();
    set_rd(5'd7, 5'd7, 2'b01);
    expect_val(S_BUSY, 2'b11, "busy_x7");
    expect_val(S_STALL, 1, "stall_x7");
    expect_val(S_BCNT, 1, "busy_cnt_one");
    next_cycle();
    set_rd(5'd7, 5'd7, 2'b00);
    expect_val(S_STALL, 0, "stall_masked_by_rd_en");
    next_cycle();
    set_rd(5'd7, 5'd0, 2'b01);
    do_wb(5'd7, 3'd3, 32'h12);
    expect_val(S_ACC, 1, "release_accept");
    expect_val(S_D0, 64'h12, "release_bypass");
    expect_val(S_BUSY, 0, "release_busy_same_cycle");
    expect_val(S_STALL, 0, "release_stall");
    expect_val(S_BCNT, 1, "release_cnt_before_edge");
    next_cycle();
    idle();
    expect_val(S_BCNT, 0, "release_cnt_after_edge");
    expect_val(S_D0, 64'h12, "release_written");
    next_cycle();

    // WAW race: stale writeback dropped
    do_issue(5'd9, 3'd1);
    next_cycle();
    do_issue(5'd9, 3'd2);
    next_cycle();
    idle();
    set_rd(5'd9, 5'd0, 2'b01);
    do_wb(5'd9, 3'd1, 32'hAA);
    expect_val(S_ACC, 0, "waw_stale_reject");
    expect_val(S_D0, 0, "waw_no_bypass");
    expect_val(S_BUSY, 2'b01, "waw_still_busy");
    next_cycle();
    idle();
    expect_val(S_D0, 0, "waw_x9_unchanged");
    expect_val(S_BCNT, 1, "waw_cnt_one");
    next_cycle();
    do_wb(5'd9, 3'd2, 32'hBB);
    expect_val(S_ACC, 1, "waw_current_accept");
    expect_val(S_D0, 64'hBB, "waw_current_bypass");
    next_cycle();
    idle();
    expect_val(S_D0, 64'hBB, "waw_x9_written");
    expect_val(S_BCNT, 0, "waw_cnt_zero");
    next_cycle();

    // Simultaneous issue and wb to the same register: issue wins, data still written
    do_issue(5'd10, 3'd1);
    next_cycle();
    do_issue(5'd10, 3'd2);
    do_wb(5'd10, 3'd1, 32'h55);
    set_rd(5'd10, 5'd0, 2'b01);
    expect_val(S_ACC, 1, "same_rd_accept_old_tag");
    expect_val(S_D0, 64'h55, "same_rd_bypass");
    next_cycle();
    idle();
    expect_val(S_BUSY, 2'b01, "same_rd_busy_new_tag");
    expect_val(S_D0, 64'h55, "same_rd_written");
    expect_val(S_BCNT, 1, "same_rd_cnt");
    next_cycle();
    do_wb(5'd10, 3'd2, 32'h66);
    expect_val(S_ACC, 1, "same_rd_new_tag_accept");
    next_cycle();
    idle();
    expect_val(S_BCNT, 0, "same_rd_cnt_zero");
    expect_val(S_D0, 64'h66, "same_rd_final");
    next_cycle();

    // x0: wb accepted but ignored, issue ignored
    set_rd(5'd0, 5'd0, 2'b11);
    do_wb(5'd0, 3'd0, 32'hFF);
    expect_val(S_ACC, 1, "x0_wb_accept");
    expect_val(S_D0, 0, "x0_no_bypass");
    next_cycle();
    idle();
    do_issue(5'd0, 3'd5);
    expect_val(S_D0, 0, "x0_reads_zero");
    next_cycle();
    idle();
    expect_val(S_BCNT, 0, "x0_never_busy_cnt");
    expect_val(S_BUSY, 0, "x0_never_busy");
    next_cycle();

    // Flush: clears busy, drops same-cycle issue, keeps registers
    do_issue(5'd3, 3'd1);
    next_cycle();
    do_issue(5'd4, 3'd2);
    next_cycle();
    idle();
    expect_val(S_BCNT, 2, "flush_pre_cnt");
    flush = 1'b1;
    do_issue(5'd6, 3'd3);
    next_cycle();
    idle();
    set_rd(5'd6, 5'd5, 2'b11);
    expect_val(S_BCNT, 0, "flush_cnt_zero");
    expect_val(S_BUSY, 0, "flush_x6_not_busy");
    expect_val(S_STALL, 0, "flush_no_stall");
    expect_val(S_D1, 64'hDEAD_BEEF, "flush_regs_kept");
    next_cycle();
    do_issue(5'd8, 3'd4);
    next_cycle();
    idle();
    flush = 1'b1;
    do_wb(5'd8, 3'd4, 32'h77);
    set_rd(5'd8, 5'd0, 2'b01);
    expect_val(S_ACC, 1, "flush_wb_pre_state");
    next_cycle();
    idle();
    expect_val(S_D0, 64'h77, "flush_wb_written");
    expect_val(S_BCNT, 0, "flush_wb_cnt");
    next_cycle();

    // Retired-instruction counter; flush during commits must not affect it
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1'b1;
      flush = (i == 1);
      expect_val(S_INST, 64'(i), "instret_step");
      next_cycle();
    end
    idle();
    expect_val(S_INST, 3, "instret_three");
    expect_val(S_WINST, 3, "wrap_inst_three");
    next_cycle();
    for (int i = 3; i < 15; i++) begin
      commit_valid = 1'b1;
      next_cycle();
    end
    idle();
    expect_val(S_WINST, 15, "wrap_all_ones");
    expect_val(S_INST, 15, "instret_fifteen");
    next_cycle();
    commit_valid = 1'b1;
    next_cycle();
    idle();
    expect_val(S_WINST, 0, "wrap_to_zero");
    expect_val(S_INST, 16, "instret_sixteen");
    next_cycle();

    // Reset mid-stream overrides issue, wb and commit
    do_issue(5'd11, 3'd1);
    next_cycle();
    idle();
    rst = 1'b0;
    do_issue(5'd12, 3'd2);
    do_wb(5'd5, 3'd0, 32'h1);
    commit_valid = 1'b1;
    next_cycle();
    rst = 1'b1;
    idle();
    set_rd(5'd5, 5'd11, 2'b11);
    expect_val(S_D0, 0, "rst_regs_cleared");
    expect_val(S_BUSY, 0, "rst_busy_cleared");
    expect_val(S_STALL, 0, "rst_stall");
    expect_val(S_BCNT, 0, "rst_busy_cnt");
    expect_val(S_INST, 0, "rst_instret");
    expect_val(S_WINST, 0, "rst_wrap_instret");
    next_cycle();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode/writeback register file: multi-read-port architectural register file with write-to-read bypass, plus a tagged busy-bit scoreboard for long-latency producers (loads, multi-cycle ALU ops).
- Sits between decode (source reads, busy check, destination allocation) and writeback/commit (result write, busy release, retired-instruction counting).
- Decode stalls on any busy source.
- Late writebacks from superseded producers are dropped so that a WAW race cannot corrupt state.

Parameters:
- XLEN, 32, register data width
- NUM_RD, 2, number of combinational read ports (1..4)
- TAG_W, 3, producer tag width carried from issue to writeback
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- rd_addr  in  NUM_RD*5  packed read addresses, port i at [5i+4:5i]
- rd_data  out  NUM_RD*XLEN  packed read data, bypassed
- rd_busy  out  NUM_RD  port i source has pending producer
- stall  out  1  OR of rd_busy over ports with rd_en set
- rd_en  in  NUM_RD  port i operand is actually used
- issue_valid  in  1  allocate destination this cycle
- issue_rd  in  5  destination register
- issue_tag  in  TAG_W  producer tag
- wb_valid  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- wb_tag  in  TAG_W  producer tag of writeback
- wb_data  in  XLEN  writeback value
- wb_accept  out  1  writeback was committed to the register file (comb.)
- commit_valid  in  1  one instruction retired
- flush  in  1  clear all busy bits (speculative squash)
- instret  out  CNT_W  retired-instruction count
- busy_cnt  out  6  number of currently busy registers

Behaviour:
- Reset (rst==0 at clk edge):
  - all 32 registers go to 0, all busy bits and tags go to 0, instret goes to 0.
  - Outputs after reset: rd_data=0, rd_busy=0, stall=0, busy_cnt=0, instret=0.
  - Reset overrides issue, wb, commit and flush in the same cycle.
- x0:
  - always reads 0 and is never busy.
  - issue and wb to x0 are ignored; wb_accept=1 for wb to x0 so the producer retires cleanly.
- Writeback acceptance (combinational):
  - wb_accept = wb_valid && (wb_rd==0 || !busy[wb_rd] || tag[wb_rd]==wb_tag).
  - An accepted write updates reg[wb_rd] at the clock edge.
  - A rejected write (busy with a different tag, i.e. superseded) is dropped silently.
- Busy release: an accepted wb with a matching tag clears busy[wb_rd] at the edge.
- Issue: issue_valid sets busy[issue_rd]=1 and tag[issue_rd]=issue_tag at the edge.
- Simultaneous issue and wb to the same rd:
  - issue wins: busy stays 1 with the new tag.
  - The wb data is still written if accepted against the old tag.
- Bypass:
  - If wb_accept && wb_rd==rd_addr[i] && wb_rd!=0, rd_data[i]=wb_data in the same cycle.
  - rd_busy[i] is 0 when that accepted wb clears the register's busy bit this cycle.
- Read latency: 0 cycles, combinational. Busy/tag/regfile updates are visible the cycle after the edge, or same-cycle via bypass.
- flush:
  - clears every busy bit at the edge; register contents are unchanged.
  - An issue in the same cycle as flush is discarded (flush wins).
  - A wb in the same cycle as flush is still evaluated against the pre-flush state.
- instret:
  - increments by 1 per commit_valid and wraps modulo 2^CNT_W without saturation.
  - Independent of flush.
- busy_cnt: registered popcount of busy bits, updated the same edge as the busy bits.

Decomposition:
- Types live in rv32i_types: rv32i_word and rv32i_reg.
- New typedef in rv32i_types: sb_tag_t (logic [TAG_W-1:0]), with a default TAG_W localparam.
- One sub-module, sb_table: busy bits, tag array, issue/wb/flush update, busy_cnt.
- The top module holds the register array, bypass muxes, per-port busy and stall logic, and instret.

Test Plan:
- Reset, then read all ports: rd_addr={5,0}, rd_en=2'b11 -> rd_data all 0, rd_busy=0, stall=0, busy_cnt=0, instret=0.
- Bypass: wb x5=32'hDEAD_BEEF, tag 0, not busy, while rd_addr[0]=5 in the same cycle -> rd_data[0]=DEADBEEF in the same cycle and on the next cycle.
- Busy/stall: issue x7 tag 3, next cycle read x7 with rd_en=1 -> rd_busy=1, stall=1, busy_cnt=1. Then wb x7 tag 3 data 0x12 -> same cycle rd_data=0x12, rd_busy=0, stall=0. Next cycle busy_cnt=0.
- WAW race:
  - issue x9 tag 1, then issue x9 tag 2.
  - wb x9 tag 1 data 0xAA -> wb_accept=0, x9 unchanged, still busy.
  - wb x9 tag 2 data 0xBB -> accept, x9=0xBB, busy clears.
- x0 and flush:
  - wb x0 data 0xFF -> wb_accept=1, read x0=0.
  - issue x3 and x4, then flush together with issue x6 -> busy_cnt=0 and x6 not busy.
- Counter and reset: 3 commit_valid pulses -> instret=3. With instret preset near wrap, 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0. Assert rst=0 mid-stream with issue_valid=1 -> all state 0 next cycle.
